// File: rtl/thread_sched.sv
// Barrel-thread scheduler feeding the instruction fetch unit.
// Picks one eligible hardware thread per cycle in round-robin order,
// holds each thread's next-fetch word address, and blocks a thread from
// re-issue until the execute stage has written back its resolved next PC.
module thread_sched #(
  parameter int              NTHREADS   = 3,
  parameter int              PC_W       = 29,
  parameter logic [PC_W-1:0] RESET_WORD = 29'h80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          thread_en,
  input  logic [2:0]          stall_req,
  input  logic                wb_valid,
  input  logic [1:0]          wb_thread,
  input  logic [PC_W-1:0]     wb_next_pc,
  output logic [1:0]          thread_id,
  output logic                issue_valid,
  output logic [PC_W-1:0]     new_pc [NTHREADS],
  output logic [2:0]          inflight,
  output logic [15:0]         idle_cnt
);

  logic [1:0]      r_threadId;
  logic            r_issueValid;
  logic [1:0]      r_last;
  logic [2:0]      r_inflight;
  logic [15:0]     r_idleCnt;
  logic [PC_W-1:0] r_pc [NTHREADS];

  logic [2:0]      w_elig;
  logic [1:0]      w_cand [3];
  logic            w_found;
  logic [1:0]      w_sel;
  logic [2:0]      w_setMask;
  logic [2:0]      w_clrMask;

  // Eligibility uses the pre-edge inflight bits, so a thread written back
  // this cycle only becomes eligible on the following cycle.
  assign w_elig = thread_en & ~stall_req & ~r_inflight;

  // Candidate order starting just after the last issued thread, wrapping mod 3.
  always_comb begin
    w_cand[0] = 2'd0;
    w_cand[1] = 2'd1;
    w_cand[2] = 2'd2;
    case (r_last)
      2'd0: begin
        w_cand[0] = 2'd1;
        w_cand[1] = 2'd2;
        w_cand[2] = 2'd0;
      end
      2'd1: begin
        w_cand[0] = 2'd2;
        w_cand[1] = 2'd0;
        w_cand[2] = 2'd1;
      end
      default: begin
        w_cand[0] = 2'd0;
        w_cand[1] = 2'd1;
        w_cand[2] = 2'd2;
      end
    endcase
  end

  // First eligible candidate in round-robin order wins the fetch slot.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    for (int i = 0; i < 3; i++) begin
      if (!w_found && w_elig[w_cand[i]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[i];
      end
    end
  end

  // One-hot masks for the inflight set (issue) and clear (writeback).
  // Thread id 3 on the writeback bus is not a real thread and is dropped.
  always_comb begin
    w_setMask = 3'b000;
    w_clrMask = 3'b000;
    if (w_found) begin
      w_setMask = 3'b001 << w_sel;
    end
    if (wb_valid && (wb_thread != 2'd3)) begin
      w_clrMask = 3'b001 << wb_thread;
    end
  end

  // Issue register, round-robin pointer and saturating idle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_threadId   <= 2'd0;
      r_issueValid <= 1'b0;
      r_last       <= 2'd2;
      r_idleCnt    <= 16'd0;
    end else if (w_found) begin
      r_threadId   <= w_sel;
      r_issueValid <= 1'b1;
      r_last       <= w_sel;
    end else begin
      r_issueValid <= 1'b0;
      if (r_idleCnt != 16'hFFFF) begin
        r_idleCnt <= r_idleCnt + 16'd1;
      end
    end
  end

  // Inflight tracking: set on issue, cleared only by writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 3'b000;
    end else begin
      r_inflight <= (r_inflight | w_setMask) & ~w_clrMask;
    end
  end

  // Per-thread next-PC registers, written only by writeback or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTHREADS; i++) begin
        r_pc[i] <= RESET_WORD;
      end
    end else begin
      for (int i = 0; i < NTHREADS; i++) begin
        if (w_clrMask[i]) begin
          r_pc[i] <= wb_next_pc;
        end
      end
    end
  end

  assign thread_id   = r_threadId;
  assign issue_valid = r_issueValid;
  assign inflight    = r_inflight;
  assign idle_cnt    = r_idleCnt;
  assign new_pc      = r_pc;

endmodule
